// File: rtl/csr_access_unit.sv
// Zicsr read-modify-write sequencer plus ECALL/MRET handling in front of the CSR file.
// Optional macro CSR_RO_CHECK_EN rejects writes to the read-only CSR space (addr[11:10]==2'b11).
module csr_access_unit #(
  parameter logic [11:0] MEPC_ADDR   = 12'h341,
  parameter logic [11:0] MCAUSE_ADDR = 12'h342,
  parameter logic [31:0] ECALL_CAUSE = 32'd11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [11:0] req_csr_addr,
  input  logic [4:0]  req_rs1_idx,
  input  logic [31:0] req_rs1_data,
  input  logic [31:0] req_pc,
  input  logic        req_ecall,
  input  logic        req_mret,
  output logic        csr_w_enable,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata,
  input  logic [31:0] csr_mtvec,
  input  logic [31:0] csr_mepc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_redirect,
  output logic [31:0] rsp_target,
  output logic        rsp_illegal
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    TRAP_EPC,
    TRAP_CAUSE,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [11:0] addr_q, addr_d;
  logic [4:0]  rs1_idx_q, rs1_idx_d;
  logic [31:0] rs1_data_q, rs1_data_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] new_q, new_d;
  logic [31:0] rdata_q, rdata_d;
  logic        redirect_q, redirect_d;
  logic [31:0] target_q, target_d;
  logic        illegal_q, illegal_d;

  logic        csr_we;
  logic [11:0] csr_addr_c;
  logic [31:0] csr_wdata_c;
  logic [31:0] operand;
  logic [31:0] new_val;
  logic        op_legal;
  logic        wr_needed;
  logic        ro_hit;

  // Operand and new-value datapath, evaluated against the live read data in READ.
  always_comb begin
    operand  = funct3_q[2] ? {27'b0, rs1_idx_q} : rs1_data_q;
    new_val  = 32'b0;
    op_legal = (funct3_q[1:0] != 2'b00);
    case (funct3_q[1:0])
      2'b01:   new_val = operand;
      2'b10:   new_val = csr_rdata | operand;
      2'b11:   new_val = csr_rdata & ~operand;
      default: new_val = 32'b0;
    endcase
    // Set/clear with x0/uimm=0 must not write, so side effects of a pure read are avoided.
    wr_needed = op_legal && ((funct3_q[1:0] == 2'b01) || (rs1_idx_q != 5'd0));
`ifdef CSR_RO_CHECK_EN
    ro_hit = wr_needed && (addr_q[11:10] == 2'b11);
`else
    ro_hit = 1'b0;
`endif
  end

  always_comb begin
    state_d     = state_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    rs1_idx_d   = rs1_idx_q;
    rs1_data_d  = rs1_data_q;
    pc_d        = pc_q;
    new_d       = new_q;
    rdata_d     = rdata_q;
    redirect_d  = redirect_q;
    target_d    = target_q;
    illegal_d   = illegal_q;
    csr_we      = 1'b0;
    csr_addr_c  = 12'b0;
    csr_wdata_c = 32'b0;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          funct3_d   = req_funct3;
          addr_d     = req_csr_addr;
          rs1_idx_d  = req_rs1_idx;
          rs1_data_d = req_rs1_data;
          pc_d       = req_pc;
          rdata_d    = 32'b0;
          redirect_d = 1'b0;
          target_d   = 32'b0;
          illegal_d  = 1'b0;
          if (req_ecall) begin
            state_d = TRAP_EPC;
          end else if (req_mret) begin
            redirect_d = 1'b1;
            target_d   = csr_mepc;
            state_d    = RESP;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        csr_addr_c = addr_q;
        rdata_d    = csr_rdata;
        new_d      = new_val;
        illegal_d  = !op_legal || ro_hit;
        state_d    = (wr_needed && !ro_hit) ? WRITE : RESP;
      end
      WRITE: begin
        csr_we      = 1'b1;
        csr_addr_c  = addr_q;
        csr_wdata_c = new_q;
        state_d     = RESP;
      end
      TRAP_EPC: begin
        csr_we      = 1'b1;
        csr_addr_c  = MEPC_ADDR;
        csr_wdata_c = pc_q;
        state_d     = TRAP_CAUSE;
      end
      TRAP_CAUSE: begin
        csr_we      = 1'b1;
        csr_addr_c  = MCAUSE_ADDR;
        csr_wdata_c = ECALL_CAUSE;
        redirect_d  = 1'b1;
        target_d    = csr_mtvec;
        state_d     = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A write scheduled in the same cycle as reset must never reach the CSR file.
  assign csr_w_enable = csr_we & ~rst;
  assign csr_addr     = rst ? 12'b0 : csr_addr_c;
  assign csr_wdata    = rst ? 32'b0 : csr_wdata_c;

  assign rsp_rdata    = rsp_valid ? rdata_q : 32'b0;
  assign rsp_redirect = rsp_valid & redirect_q;
  assign rsp_target   = rsp_valid ? target_q : 32'b0;
  assign rsp_illegal  = rsp_valid & illegal_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      funct3_q   <= 3'b0;
      addr_q     <= 12'b0;
      rs1_idx_q  <= 5'b0;
      rs1_data_q <= 32'b0;
      pc_q       <= 32'b0;
      new_q      <= 32'b0;
      rdata_q    <= 32'b0;
      redirect_q <= 1'b0;
      target_q   <= 32'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      rs1_idx_q  <= rs1_idx_d;
      rs1_data_q <= rs1_data_d;
      pc_q       <= pc_d;
      new_q      <= new_d;
      rdata_q    <= rdata_d;
      redirect_q <= redirect_d;
      target_q   <= target_d;
      illegal_q  <= illegal_d;
    end
  end

endmodule
